regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
Parametrised multi-port register file; successor to the single-write, two-read 16x16 register file in the CPU datapath. Adds configurable width, depth and read/write port counts, optional hardwired-zero r0, optional write-to-read bypass, and a per-register busy scoreboard for pipelined issue. Sits between decode (read and reserve) and writeback (write).

Parameters:
DATA_W, 16, register width in bits
ADDR_W, 4, select width; depth = 2**ADDR_W
NUM_RD, 2, read ports
NUM_WR, 2, write ports; port 0 lowest priority, port NUM_WR-1 highest
ZERO_REG, 1, 1 = r0 reads 0, ignores writes, never busy
BYPASS, 1, 1 = same-cycle write data forwarded to reads

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
wen  in  NUM_WR  per-write-port enable
selWr  in  NUM_WR*ADDR_W  write selects, port k at [k*ADDR_W +: ADDR_W]
dataWr  in  NUM_WR*DATA_W  write data, same packing
selRd  in  NUM_RD*ADDR_W  read selects
dataRd  out  NUM_RD*DATA_W  read data
busyRd  out  NUM_RD  busy flag of each read-selected register
rsvEn  in  1  reserve request: mark selRsv busy
selRsv  in  ADDR_W  register to reserve
anyBusy  out  1  OR of all busy bits

Behaviour:
- Reset: rst_n low asynchronously clears all registers to 0 and all busy bits to 0. dataRd, busyRd and anyBusy follow combinationally, so they read 0 while reset is held. Deassertion is taken synchronously by the next clk edge; no write is taken on an edge while rst_n is low.
- Write: on rising clk, each port k with wen[k]=1 writes dataWr[k] to selWr[k].
- Same-address multi-write in one cycle: the highest-indexed enabled port wins.
- ZERO_REG=1: writes to address 0 are dropped.
- Read (combinational, zero latency):
  - BYPASS=0: dataRd[j] = stored register.
  - BYPASS=1: if any enabled write port targets selRd[j] this cycle, dataRd[j] = winning write data, otherwise stored value.
  - ZERO_REG=1 and selRd[j]=0: always 0, regardless of bypass.
- Scoreboard, per register, one cycle to take effect:
  - rsvEn=1 sets busy[selRsv] at the edge.
  - Any enabled write to a register clears its busy bit at the edge.
  - Reserve and write to the same register in the same cycle: the reserve wins, busy=1 (new producer issued).
  - Reserve to r0 with ZERO_REG=1 is ignored.
- busyRd:
  - BYPASS=0: busyRd[j] = busy[selRd[j]].
  - BYPASS=1: busyRd[j] is forced 0 when an enabled write hits selRd[j] this cycle (data is valid via the bypass).
- anyBusy = OR of all registered busy bits; no bypass applies.
- Out-of-range selects cannot occur (depth = 2**ADDR_W).
- X on a disabled port's sel/data must not affect any state or output.

Decomposition:
- Shared package: DATA_W/ADDR_W defaults, packed-slice helper macros (slice k of a flat vector).
- One sub-module, regfile_wr_arb: per-address write resolution (priority select of winning port, hit flag, winning data). It is used both by the storage update and by the bypass path, so both agree on the winning write.

Test Plan:
1. Hold rst_n=0 after writing 16'hBEEF to r5, then release -> all 16 regs read 0, anyBusy=0; a write on an edge during reset is not taken.
2. Write r3=16'h1234 on port 0 and r3=16'h5678 on port 1 in the same cycle -> r3=16'h5678 next cycle. With BYPASS=1, selRd[0]=3 reads 16'h5678 in the write cycle itself.
3. ZERO_REG=1: write r0=16'hFFFF and rsvEn to r0 -> dataRd=0, busyRd=0, anyBusy=0.
4. rsvEn on r7 -> next cycle busyRd=1 for selRd=7 and anyBusy=1. Then write r7=16'h00AA -> in the write cycle busyRd=0 and data 16'h00AA when BYPASS=1 (busyRd=1, old data when BYPASS=0); after the edge, busy=0.
5. Same cycle: rsvEn on r9 and write r9=16'h0042 -> after the edge r9=16'h0042 and busy[9]=1.
6. Sweep with NUM_RD=3, NUM_WR=1, DATA_W=32, ADDR_W=5: write reg i = i*32'h01010101 for i=0..31, read back on all 3 ports -> exact match, with r0=0 when ZERO_REG=1.

Source files
------------

// File: rtl/regfile_mp_pkg.sv
// -----------------------------------------------------------------------------
// regfile_mp_pkg
// Shared defaults and helpers for the multi-port register file.
//   RF_DATA_W / RF_ADDR_W  : default register width and select width
//   RF_NUM_RD / RF_NUM_WR  : default read / write port counts
//   `RF_SLICE(vec, k, w)   : slice k of a flat vector packed as k*w +: w
// -----------------------------------------------------------------------------
`ifndef RF_SLICE
`define RF_SLICE(vec, k, w) vec[(k)*(w) +: (w)]
`endif

package regfile_mp_pkg;
    localparam int RF_DATA_W = 16;
    localparam int RF_ADDR_W = 4;
    localparam int RF_NUM_RD = 2;
    localparam int RF_NUM_WR = 2;
endpackage

// File: rtl/regfile_wr_arb.sv
// -----------------------------------------------------------------------------
// regfile_wr_arb
// Resolves all write ports against one register address. Reports whether any
// enabled port targets the address and, if so, the data of the winning port
// (the highest-indexed enabled port).
//   i_wen    : per-port write enable
//   i_selWr  : flat write selects, port k at [k*ADDR_W +: ADDR_W]
//   i_dataWr : flat write data,    port k at [k*DATA_W +: DATA_W]
//   i_addr   : register address this instance resolves
//   o_hit    : an enabled write targets i_addr
//   o_data   : winning write data (0 when no hit)
// -----------------------------------------------------------------------------
module regfile_wr_arb
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_WR   = RF_NUM_WR,
    parameter int ZERO_REG = 1
) (
    input  logic [NUM_WR-1:0]        i_wen,
    input  logic [NUM_WR*ADDR_W-1:0] i_selWr,
    input  logic [NUM_WR*DATA_W-1:0] i_dataWr,
    input  logic [ADDR_W-1:0]        i_addr,
    output logic                     o_hit,
    output logic [DATA_W-1:0]        o_data
);

    // Ascending scan: a later (higher-indexed) match overrides an earlier one.
    // The enable is tested first so a disabled port's select/data never matters.
    // A hardwired r0 never reports a hit, so it is neither written nor bypassed.
    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        for (int k = 0; k < NUM_WR; k++) begin
            if (i_wen[k] && (`RF_SLICE(i_selWr, k, ADDR_W) == i_addr)) begin
                o_hit  = 1'b1;
                o_data = `RF_SLICE(i_dataWr, k, DATA_W);
            end
        end
        if ((ZERO_REG != 0) && (i_addr == '0)) begin
            o_hit  = 1'b0;
            o_data = '0;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
// Parametrised multi-port register file with optional hardwired-zero r0,
// optional write-to-read bypass and a per-register busy scoreboard.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   wen        : per-write-port enable (higher index = higher priority)
//   selWr      : flat write selects, port k at [k*ADDR_W +: ADDR_W]
//   dataWr     : flat write data, same packing
//   selRd      : flat read selects
//   dataRd     : flat read data (combinational)
//   busyRd     : busy flag of each read-selected register
//   rsvEn      : reserve request, marks selRsv busy at the next edge
//   selRsv     : register to reserve
//   anyBusy    : OR of all registered busy bits
// -----------------------------------------------------------------------------
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_RD   = RF_NUM_RD,
    parameter int NUM_WR   = RF_NUM_WR,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_WR-1:0]        wen,
    input  logic [NUM_WR*ADDR_W-1:0] selWr,
    input  logic [NUM_WR*DATA_W-1:0] dataWr,
    input  logic [NUM_RD*ADDR_W-1:0] selRd,
    output logic [NUM_RD*DATA_W-1:0] dataRd,
    output logic [NUM_RD-1:0]        busyRd,
    input  logic                     rsvEn,
    input  logic [ADDR_W-1:0]        selRsv,
    output logic                     anyBusy
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]  r_busy;

    logic [DEPTH-1:0]  w_wrHit;
    logic [DATA_W-1:0] w_wrData [DEPTH];
    logic [DEPTH-1:0]  w_rsvHit;
    logic [ADDR_W-1:0] w_rdSel;

    // One arbiter per address. The storage update and the read bypass both
    // index these same results, so they can never disagree on the winner.
    for (genvar a = 0; a < DEPTH; a++) begin : g_addr
        regfile_wr_arb #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .NUM_WR   (NUM_WR),
            .ZERO_REG (ZERO_REG)
        ) u_arb (
            .i_wen    (wen),
            .i_selWr  (selWr),
            .i_dataWr (dataWr),
            .i_addr   (ADDR_W'(a)),
            .o_hit    (w_wrHit[a]),
            .o_data   (w_wrData[a])
        );

        assign w_rsvHit[a] = rsvEn && (selRsv == ADDR_W'(a)) && !((ZERO_REG != 0) && (a == 0));
    end

    // Storage and scoreboard. A reserve beats a same-cycle write on the busy
    // bit because the reserve represents a newer producer already in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_regs <= '{default: '0};
            r_busy <= '0;
        end else begin
            for (int a = 0; a < DEPTH; a++) begin
                if (w_wrHit[a]) begin
                    r_regs[a] <= w_wrData[a];
                end
                if (w_rsvHit[a]) begin
                    r_busy[a] <= 1'b1;
                end else if (w_wrHit[a]) begin
                    r_busy[a] <= 1'b0;
                end
            end
        end
    end

    // Read ports. Outputs are forced to 0 while reset is held so a pending
    // write cannot leak through the bypass. r0 needs no special case here:
    // with ZERO_REG its arbiter never hits and its storage/busy stay 0.
    always_comb begin
        dataRd  = '0;
        busyRd  = '0;
        w_rdSel = '0;
        for (int j = 0; j < NUM_RD; j++) begin
            w_rdSel = `RF_SLICE(selRd, j, ADDR_W);
            if (rst_n) begin
                if ((BYPASS != 0) && w_wrHit[w_rdSel]) begin
                    `RF_SLICE(dataRd, j, DATA_W) = w_wrData[w_rdSel];
                    busyRd[j] = 1'b0;
                end else begin
                    `RF_SLICE(dataRd, j, DATA_W) = r_regs[w_rdSel];
                    busyRd[j] = r_busy[w_rdSel];
                end
            end
        end
    end

    assign anyBusy = |r_busy;

endmodule

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp
// Directed bench for regfile_mp. Three instances:
//   dutA : defaults (16x16, 2R/2W, ZERO_REG=1, BYPASS=1)
//   dutB : same shape with ZERO_REG=0, BYPASS=0, driven by the same inputs
//   dutC : 32x32, 3R/1W sweep configuration
// -----------------------------------------------------------------------------
module tb_regfile_mp;

    logic        clk;
    logic        rst_n;

    logic [1:0]  wen;
    logic [7:0]  selWr;
    logic [31:0] dataWr;
    logic [7:0]  selRd;
    logic        rsvEn;
    logic [3:0]  selRsv;

    logic [31:0] dataRdA, dataRdB;
    logic [1:0]  busyRdA, busyRdB;
    logic        anyBusyA, anyBusyB;

    logic        cWen;
    logic [4:0]  cSelWr;
    logic [31:0] cDataWr;
    logic [14:0] cSelRd;
    logic [95:0] cDataRd;
    logic [2:0]  cBusyRd;
    logic        cAnyBusy;

    int passCount;
    int checkCount;

    regfile_mp dutA (
        .clk(clk), .rst_n(rst_n), .wen(wen), .selWr(selWr), .dataWr(dataWr),
        .selRd(selRd), .dataRd(dataRdA), .busyRd(busyRdA), .rsvEn(rsvEn),
        .selRsv(selRsv), .anyBusy(anyBusyA)
    );

    regfile_mp #(.ZERO_REG(0), .BYPASS(0)) dutB (
        .clk(clk), .rst_n(rst_n), .wen(wen), .selWr(selWr), .dataWr(dataWr),
        .selRd(selRd), .dataRd(dataRdB), .busyRd(busyRdB), .rsvEn(rsvEn),
        .selRsv(selRsv), .anyBusy(anyBusyB)
    );

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(3), .NUM_WR(1)) dutC (
        .clk(clk), .rst_n(rst_n), .wen(cWen), .selWr(cSelWr), .dataWr(cDataWr),
        .selRd(cSelRd), .dataRd(cDataRd), .busyRd(cBusyRd), .rsvEn(1'b0),
        .selRsv(5'd0), .anyBusy(cAnyBusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle of stimulus and the outputs expected during that cycle,
    // before the edge that commits it.
    typedef struct {
        logic [1:0]  wen;
        logic [7:0]  selWr;
        logic [31:0] dataWr;
        logic [7:0]  selRd;
        logic        rsvEn;
        logic [3:0]  selRsv;
        logic [31:0] expDataA;
        logic [1:0]  expBusyA;
        logic        expAnyA;
        logic [31:0] expDataB;
        logic [1:0]  expBusyB;
        logic        expAnyB;
    } vec_t;

    vec_t vecs [12];

    task automatic checkOutput(input string name, input logic [95:0] act, input logic [95:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        wen    = v.wen;
        selWr  = v.selWr;
        dataWr = v.dataWr;
        selRd  = v.selRd;
        rsvEn  = v.rsvEn;
        selRsv = v.selRsv;
    endtask

    function automatic logic [31:0] sweepValue(input int i);
        return (i == 0) ? 32'h0 : 32'(i) * 32'h01010101;
    endfunction

    initial begin
        passCount  = 0;
        checkCount = 0;

        //          wen    selWr  dataWr                    selRd  rsv   sel   expDataA      bA     aA    expDataB      bB     aB
        vecs[0]  = '{2'b11, 8'h33, 32'h5678_1234,            8'h03, 1'b0, 4'h0, 32'h0000_5678, 2'b00, 1'b0, 32'h0000_0000, 2'b00, 1'b0};
        vecs[1]  = '{2'b00, 8'h00, 32'h0000_0000,            8'h03, 1'b0, 4'h0, 32'h0000_5678, 2'b00, 1'b0, 32'h0000_5678, 2'b00, 1'b0};
        vecs[2]  = '{2'b01, 8'h00, 32'h0000_FFFF,            8'h00, 1'b1, 4'h0, 32'h0000_0000, 2'b00, 1'b0, 32'h0000_0000, 2'b00, 1'b0};
        vecs[3]  = '{2'b00, 8'h00, 32'h0000_0000,            8'h00, 1'b0, 4'h0, 32'h0000_0000, 2'b00, 1'b0, 32'hFFFF_FFFF, 2'b11, 1'b1};
        vecs[4]  = '{2'b01, 8'h00, 32'h0000_0000,            8'h07, 1'b1, 4'h7, 32'h0000_0000, 2'b00, 1'b0, 32'hFFFF_0000, 2'b10, 1'b1};
        vecs[5]  = '{2'b00, 8'h00, 32'h0000_0000,            8'h07, 1'b0, 4'h0, 32'h0000_0000, 2'b01, 1'b1, 32'h0000_0000, 2'b01, 1'b1};
        vecs[6]  = '{2'b10, {4'h7, 4'hx}, {16'h00AA, 16'hxxxx}, 8'h07, 1'b0, 4'h0, 32'h0000_00AA, 2'b00, 1'b1, 32'h0000_0000, 2'b01, 1'b1};
        vecs[7]  = '{2'b00, 8'h00, 32'h0000_0000,            8'h07, 1'b0, 4'h0, 32'h0000_00AA, 2'b00, 1'b0, 32'h0000_00AA, 2'b00, 1'b0};
        vecs[8]  = '{2'b01, 8'h09, 32'h0000_0042,            8'h79, 1'b1, 4'h9, 32'h00AA_0042, 2'b00, 1'b0, 32'h00AA_0000, 2'b00, 1'b0};
        vecs[9]  = '{2'b00, 8'h00, 32'h0000_0000,            8'h79, 1'b0, 4'h0, 32'h00AA_0042, 2'b01, 1'b1, 32'h00AA_0042, 2'b01, 1'b1};
        vecs[10] = '{2'b11, 8'h42, 32'h2222_1111,            8'h42, 1'b0, 4'h0, 32'h2222_1111, 2'b00, 1'b1, 32'h0000_0000, 2'b00, 1'b1};
        vecs[11] = '{2'b00, 8'h00, 32'h0000_0000,            8'h42, 1'b0, 4'h0, 32'h2222_1111, 2'b00, 1'b1, 32'h2222_1111, 2'b00, 1'b1};

        rst_n   = 1'b0;
        wen     = '0;
        selWr   = '0;
        dataWr  = '0;
        selRd   = '0;
        rsvEn   = 1'b0;
        selRsv  = '0;
        cWen    = 1'b0;
        cSelWr  = '0;
        cDataWr = '0;
        cSelRd  = '0;

        // Reset scenario: write BEEF to r5, reset asynchronously mid-cycle,
        // attempt a write and a reserve across an edge while reset is held.
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        wen = 2'b01; selWr = 8'h05; dataWr = 32'h0000_BEEF;
        @(posedge clk); #1;
        wen = 2'b00; selRd = 8'h05;
        #1;
        checkOutput("preResetA", {64'h0, dataRdA}, {64'h0, 32'h0000_BEEF});
        checkOutput("preResetB", {64'h0, dataRdB}, {64'h0, 32'h0000_BEEF});
        #1 rst_n = 1'b0;
        #1;
        checkOutput("asyncClearA", {64'h0, dataRdA}, 96'h0);
        wen = 2'b01; selWr = 8'h05; dataWr = 32'h0000_1234;
        rsvEn = 1'b1; selRsv = 4'h5; selRd = 8'h55;
        #1;
        checkOutput("inResetDataA", {64'h0, dataRdA}, 96'h0);
        checkOutput("inResetBusyA", {94'h0, busyRdA}, 96'h0);
        checkOutput("inResetDataB", {64'h0, dataRdB}, 96'h0);
        @(posedge clk); #1;
        wen = 2'b00; rsvEn = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            selRd = {4'(i), 4'(i)};
            #1;
            checkOutput($sformatf("postResetA_r%0d", i), {62'h0, busyRdA, dataRdA}, 96'h0);
            checkOutput($sformatf("postResetB_r%0d", i), {62'h0, busyRdB, dataRdB}, 96'h0);
        end
        checkOutput("postResetAnyA", {95'h0, anyBusyA}, 96'h0);
        checkOutput("postResetAnyB", {95'h0, anyBusyB}, 96'h0);
        @(posedge clk); #1;

        // Table-driven cycles: priority, zero register, scoreboard, bypass.
        for (int v = 0; v < 12; v++) begin
            applyStimulus(vecs[v]);
            #2;
            checkOutput($sformatf("vec%0d_dataA", v), {64'h0, dataRdA}, {64'h0, vecs[v].expDataA});
            checkOutput($sformatf("vec%0d_busyA", v), {94'h0, busyRdA}, {94'h0, vecs[v].expBusyA});
            checkOutput($sformatf("vec%0d_anyA", v), {95'h0, anyBusyA}, {95'h0, vecs[v].expAnyA});
            checkOutput($sformatf("vec%0d_dataB", v), {64'h0, dataRdB}, {64'h0, vecs[v].expDataB});
            checkOutput($sformatf("vec%0d_busyB", v), {94'h0, busyRdB}, {94'h0, vecs[v].expBusyB});
            checkOutput($sformatf("vec%0d_anyB", v), {95'h0, anyBusyB}, {95'h0, vecs[v].expAnyB});
            @(posedge clk); #1;
        end
        wen = 2'b00; rsvEn = 1'b0;

        // Wide sweep on the 3R/1W instance.
        for (int i = 0; i < 32; i++) begin
            cWen    = 1'b1;
            cSelWr  = 5'(i);
            cDataWr = 32'(i) * 32'h01010101;
            @(posedge clk); #1;
        end
        cWen = 1'b0;
        for (int i = 0; i < 32; i++) begin
            cSelRd = {5'((i + 2) % 32), 5'((i + 1) % 32), 5'(i)};
            #1;
            checkOutput($sformatf("sweep_r%0d", i), cDataRd,
                        {sweepValue((i + 2) % 32), sweepValue((i + 1) % 32), sweepValue(i)});
        end
        checkOutput("sweepBusy", {92'h0, cAnyBusy, cBusyRd}, 96'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
